// File: rtl/multi_color_tracker.sv
// multi_color_tracker: per-frame bounding boxes for NUM_TRACKERS colour windows over a raster pixel stream; optional TRACKER_SOF_EN adds in_sof/sof_err
module multi_color_tracker #(
  parameter int WIDTH        = 720,
  parameter int HEIGHT       = 540,
  parameter int NUM_TRACKERS = 4,
  parameter int COORD_W      = 12,
  parameter int CNT_W        = 20
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [23:0]                     in_din,
  input  logic [24*NUM_TRACKERS-1:0]      cfg_lo,
  input  logic [24*NUM_TRACKERS-1:0]      cfg_hi,
  input  logic [CNT_W-1:0]                cfg_min_pixels,
  output logic                            out_valid,
  output logic [NUM_TRACKERS-1:0]         out_found,
  output logic [COORD_W*NUM_TRACKERS-1:0] out_center_x,
  output logic [COORD_W*NUM_TRACKERS-1:0] out_center_y,
  output logic [COORD_W*NUM_TRACKERS-1:0] out_width,
  output logic [COORD_W*NUM_TRACKERS-1:0] out_height,
  output logic [15:0]                     frame_count
`ifdef TRACKER_SOF_EN
  ,
  input  logic                            in_sof,
  output logic                            sof_err
`endif
);
  typedef enum logic [1:0] {ACCUM, REPORT0, REPORT1} state_t;
  state_t state_q, state_d;
  logic accept, clr, last;
  logic [COORD_W-1:0] x_q, y_q, px_x, px_y;
  logic [COORD_W:0] sum_x, sum_y;
  logic [NUM_TRACKERS-1:0] seen_q, seen_b, match, found_c, st_found_q;
  logic [CNT_W-1:0] cnt_q [NUM_TRACKERS];
  logic [CNT_W-1:0] cnt_b [NUM_TRACKERS];
  logic [COORD_W-1:0] min_x_q [NUM_TRACKERS];
  logic [COORD_W-1:0] max_x_q [NUM_TRACKERS];
  logic [COORD_W-1:0] min_y_q [NUM_TRACKERS];
  logic [COORD_W-1:0] max_y_q [NUM_TRACKERS];
  logic [COORD_W*NUM_TRACKERS-1:0] cx_c, cy_c, w_c, h_c, st_cx_q, st_cy_q, st_w_q, st_h_q;

  assign accept = in_valid && in_ready;
`ifdef TRACKER_SOF_EN
  assign clr = accept && in_sof;
`else
  assign clr = 1'b0;
`endif
  assign px_x = clr ? '0 : x_q;
  assign px_y = clr ? '0 : y_q;
  assign last = px_x == COORD_W'(WIDTH-1) && px_y == COORD_W'(HEIGHT-1);

  // next state: one pass through the two report cycles after the last beat
  always_comb begin
    state_d = state_q == ACCUM   ? (accept && last ? REPORT0 : ACCUM) :
              state_q == REPORT0 ? REPORT1 : ACCUM;
  end

  // per-tracker colour window match and accumulator base (an SOF beat restarts from empty)
  always_comb begin
    match  = '0;
    seen_b = seen_q & ~{NUM_TRACKERS{clr}};
    for (int k = 0; k < NUM_TRACKERS; k++) begin
      cnt_b[k] = clr ? '0 : cnt_q[k];
      match[k] = 1'b1;
      for (int j = 0; j < 3; j++)
        match[k] = match[k] && in_din[8*j +: 8] >= cfg_lo[24*k+8*j +: 8] && in_din[8*j +: 8] <= cfg_hi[24*k+8*j +: 8];
    end
  end

  // frame results from the accumulators; trackers not found report zeros
  always_comb begin
    found_c = '0;
    cx_c    = '0;
    cy_c    = '0;
    w_c     = '0;
    h_c     = '0;
    sum_x   = '0;
    sum_y   = '0;
    for (int k = 0; k < NUM_TRACKERS; k++) begin
      found_c[k] = seen_q[k] && cnt_q[k] >= cfg_min_pixels;
      sum_x = {1'b0, min_x_q[k]} + {1'b0, max_x_q[k]};
      sum_y = {1'b0, min_y_q[k]} + {1'b0, max_y_q[k]};
      cx_c[COORD_W*k +: COORD_W] = found_c[k] ? sum_x[COORD_W:1] : '0;
      cy_c[COORD_W*k +: COORD_W] = found_c[k] ? sum_y[COORD_W:1] : '0;
      w_c[COORD_W*k +: COORD_W]  = found_c[k] ? max_x_q[k] - min_x_q[k] + COORD_W'(1) : '0;
      h_c[COORD_W*k +: COORD_W]  = found_c[k] ? max_y_q[k] - min_y_q[k] + COORD_W'(1) : '0;
    end
  end

  // raster position, accumulation, result staging and reporting
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ACCUM;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      seen_q       <= '0;
      st_found_q   <= '0;
      st_cx_q      <= '0;
      st_cy_q      <= '0;
      st_w_q       <= '0;
      st_h_q       <= '0;
      out_found    <= '0;
      out_center_x <= '0;
      out_center_y <= '0;
      out_width    <= '0;
      out_height   <= '0;
      frame_count  <= '0;
      for (int k = 0; k < NUM_TRACKERS; k++) begin
        cnt_q[k]   <= '0;
        min_x_q[k] <= '0;
        max_x_q[k] <= '0;
        min_y_q[k] <= '0;
        max_y_q[k] <= '0;
      end
`ifdef TRACKER_SOF_EN
      sof_err <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      in_ready  <= state_d == ACCUM;
      out_valid <= state_q == REPORT1;
      if (accept) begin
        x_q    <= px_x == COORD_W'(WIDTH-1) ? '0 : px_x + COORD_W'(1);
        y_q    <= px_x == COORD_W'(WIDTH-1) ? px_y + COORD_W'(1) : px_y;
        seen_q <= seen_b | match;
        for (int k = 0; k < NUM_TRACKERS; k++) begin
          cnt_q[k] <= match[k] ? (&cnt_b[k] ? cnt_b[k] : cnt_b[k] + CNT_W'(1)) : cnt_b[k];
          if (match[k]) begin
            min_x_q[k] <= !seen_b[k] || px_x < min_x_q[k] ? px_x : min_x_q[k];
            max_x_q[k] <= !seen_b[k] || px_x > max_x_q[k] ? px_x : max_x_q[k];
            min_y_q[k] <= !seen_b[k] || px_y < min_y_q[k] ? px_y : min_y_q[k];
            max_y_q[k] <= !seen_b[k] || px_y > max_y_q[k] ? px_y : max_y_q[k];
          end
        end
`ifdef TRACKER_SOF_EN
        if (!in_sof && x_q == '0 && y_q == '0) sof_err <= 1'b1;
`endif
      end
      if (state_q == REPORT0) begin
        st_found_q <= found_c;
        st_cx_q    <= cx_c;
        st_cy_q    <= cy_c;
        st_w_q     <= w_c;
        st_h_q     <= h_c;
      end
      if (state_q == REPORT1) begin
        out_found    <= st_found_q;
        out_center_x <= st_cx_q;
        out_center_y <= st_cy_q;
        out_width    <= st_w_q;
        out_height   <= st_h_q;
        frame_count  <= frame_count + 16'd1;
        x_q          <= '0;
        y_q          <= '0;
        seen_q       <= '0;
        for (int k = 0; k < NUM_TRACKERS; k++) cnt_q[k] <= '0;
      end
    end
  end
endmodule

// File: tb/tb_multi_color_tracker.sv
// tb_multi_color_tracker: table vectors, hand sequences and random frames against a frame-level model
module tb_multi_color_tracker;
  localparam int W = 16, H = 8, N = 4, CW = 12, NW = 20, NP = W * H;

  logic clock = 0, reset = 0, in_valid = 0;
  logic in_ready, out_valid;
  logic [23:0] in_din = '0;
  logic [24*N-1:0] cfg_lo = '0, cfg_hi = '0;
  logic [NW-1:0] cfg_min_pixels = '0;
  logic [N-1:0] out_found;
  logic [CW*N-1:0] out_center_x, out_center_y, out_width, out_height;
  logic [15:0] frame_count;

  int total = 0, bad = 0, vcount = 0, exp_fc = 0;
  logic [23:0] px [NP];
  int e_f [N], e_cx [N], e_cy [N], e_w [N], e_h [N];
  logic [7:0] pal [5] = '{8'd0, 8'd60, 8'd128, 8'd200, 8'd255};

  typedef struct {
    logic [23:0] color;
    int bx, by, bw, bh, trk;
    logic [23:0] lo, hi;
    int minp, ef, ecx, ecy, ew, eh;
  } vec_t;
  vec_t tbl [6];

  multi_color_tracker #(.WIDTH(W), .HEIGHT(H), .NUM_TRACKERS(N), .COORD_W(CW), .CNT_W(NW)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_din(in_din),
    .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .cfg_min_pixels(cfg_min_pixels),
    .out_valid(out_valid), .out_found(out_found), .out_center_x(out_center_x),
    .out_center_y(out_center_y), .out_width(out_width), .out_height(out_height),
    .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (reset && out_valid) vcount++;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 0;
    in_valid = 0;
    tick;
    tick;
    chk("rst_ready", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_found", out_found, 0);
    chk("rst_fc", frame_count, 0);
    chk("rst_cx", out_center_x, 0);
    reset = 1;
    tick;
    chk("ready_after_rst", in_ready, 1);
    exp_fc = 0;
  endtask

  task automatic send_beat(input logic [23:0] p, input bit gaps);
    int g = 0;
    if (gaps) for (int i = 0; i < 4 && $urandom_range(0, 1) == 1; i++) begin
      in_valid = 0;
      tick;
    end
    in_din = p;
    in_valid = 1;
    while (!in_ready && g < 10) begin
      tick;
      g++;
    end
    if (g >= 10) chk("ready_timeout", 0, 1);
    tick;
    in_valid = 0;
  endtask

  task automatic send_frame(input int nbeats, input bit gaps);
    for (int i = 0; i < nbeats; i++) send_beat(px[i], gaps);
  endtask

  task automatic wait_report(input string nm);
    int lat = 0;
    while (!out_valid && lat < 8) begin
      if (lat < 2) chk({nm, "_stall"}, in_ready, 0);
      tick;
      lat++;
    end
    chk({nm, "_lat"}, lat, 2);
    chk({nm, "_ready_back"}, in_ready, 1);
    exp_fc++;
    chk({nm, "_fc"}, frame_count, exp_fc);
    tick;
    chk({nm, "_pulse"}, out_valid, 0);
  endtask

  task automatic check_all(input string nm);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("%s_t%0d_found", nm, k), out_found[k], e_f[k]);
      chk($sformatf("%s_t%0d_cx", nm, k), out_center_x[CW*k +: CW], e_cx[k]);
      chk($sformatf("%s_t%0d_cy", nm, k), out_center_y[CW*k +: CW], e_cy[k]);
      chk($sformatf("%s_t%0d_w", nm, k), out_width[CW*k +: CW], e_w[k]);
      chk($sformatf("%s_t%0d_h", nm, k), out_height[CW*k +: CW], e_h[k]);
    end
  endtask

  task automatic fill(input logic [23:0] c, input int bx, input int by, input int bw, input int bh);
    for (int p = 0; p < NP; p++)
      px[p] = (p % W >= bx && p % W < bx + bw && p / W >= by && p / W < by + bh) ? c : 24'h0;
  endtask

  task automatic clear_exp;
    for (int k = 0; k < N; k++) begin
      e_f[k] = 0; e_cx[k] = 0; e_cy[k] = 0; e_w[k] = 0; e_h[k] = 0;
    end
  endtask

  function automatic void model_frame();
    for (int k = 0; k < N; k++) begin
      int n, x0, x1, y0, y1;
      n = 0; x0 = W; x1 = -1; y0 = H; y1 = -1;
      for (int p = 0; p < NP; p++) begin
        bit m;
        m = 1;
        for (int j = 0; j < 3; j++)
          if (px[p][8*j +: 8] < cfg_lo[24*k+8*j +: 8] || px[p][8*j +: 8] > cfg_hi[24*k+8*j +: 8]) m = 0;
        if (m) begin
          n++;
          if (p % W < x0) x0 = p % W;
          if (p % W > x1) x1 = p % W;
          if (p / W < y0) y0 = p / W;
          if (p / W > y1) y1 = p / W;
        end
      end
      e_f[k]  = (n > 0 && n >= int'(cfg_min_pixels)) ? 1 : 0;
      e_cx[k] = e_f[k] ? (x0 + x1) / 2 : 0;
      e_cy[k] = e_f[k] ? (y0 + y1) / 2 : 0;
      e_w[k]  = e_f[k] ? x1 - x0 + 1 : 0;
      e_h[k]  = e_f[k] ? y1 - y0 + 1 : 0;
    end
  endfunction

  initial begin
    int v0;
    tbl[0] = '{24'h00FF00, 6, 2, 4, 4, 0, 24'h00C800, 24'h32FF32, 16, 1, 7, 3, 4, 4};
    tbl[1] = '{24'h00FF00, 6, 2, 4, 4, 0, 24'h00C800, 24'h32FF32, 17, 0, 0, 0, 0, 0};
    tbl[2] = '{24'h0000FF, 0, 0, 1, 1, 1, 24'h0000C8, 24'h3232FF, 1, 1, 0, 0, 1, 1};
    tbl[3] = '{24'hFF0000, 13, 6, 3, 2, 2, 24'hC80000, 24'hFF3232, 0, 1, 14, 6, 3, 2};
    tbl[4] = '{24'h00FF00, 3, 3, 2, 2, 3, 24'h00FF01, 24'h00FF00, 0, 0, 0, 0, 0, 0};
    tbl[5] = '{24'h32FF32, 15, 0, 1, 1, 0, 24'h00C800, 24'h32FF32, 1, 1, 15, 0, 1, 1};

    do_reset;

    for (int i = 0; i < 6; i++) begin
      cfg_lo = {N{24'hFFFFFF}};
      cfg_hi = {N{24'h000000}};
      cfg_lo[24*tbl[i].trk +: 24] = tbl[i].lo;
      cfg_hi[24*tbl[i].trk +: 24] = tbl[i].hi;
      cfg_min_pixels = NW'(tbl[i].minp);
      fill(tbl[i].color, tbl[i].bx, tbl[i].by, tbl[i].bw, tbl[i].bh);
      clear_exp;
      e_f[tbl[i].trk] = tbl[i].ef;
      e_cx[tbl[i].trk] = tbl[i].ecx;
      e_cy[tbl[i].trk] = tbl[i].ecy;
      e_w[tbl[i].trk] = tbl[i].ew;
      e_h[tbl[i].trk] = tbl[i].eh;
      send_frame(NP, 0);
      wait_report($sformatf("vec%0d", i));
      check_all($sformatf("vec%0d", i));
    end

    do_reset;
    cfg_lo = {N{24'hFFFFFF}};
    cfg_hi = {N{24'h000000}};
    cfg_lo[23:0] = 24'h00C800;
    cfg_hi[23:0] = 24'h32FF32;
    cfg_min_pixels = 1;
    fill(24'h00FF00, 2, 2, 2, 2);
    send_frame(NP, 0);
    wait_report("move1");
    chk("move1_cx", out_center_x[CW-1:0], 2);
    chk("move1_w", out_width[CW-1:0], 2);
    fill(24'h00FF00, 12, 6, 2, 2);
    send_frame(NP, 0);
    wait_report("move2");
    chk("move2_cx", out_center_x[CW-1:0], 12);
    chk("move2_cy", out_center_y[CW-1:0], 6);
    chk("move2_w", out_width[CW-1:0], 2);
    chk("move2_h", out_height[CW-1:0], 2);
    chk("move2_fc", frame_count, 2);

    v0 = vcount;
    fill(24'h00FF00, 1, 1, 3, 3);
    send_frame(60, 0);
    reset = 0;
    tick;
    tick;
    reset = 1;
    tick;
    exp_fc = 0;
    chk("midrst_fc", frame_count, 0);
    chk("midrst_novalid", vcount, v0);
    fill(24'h00FF00, 9, 5, 3, 2);
    clear_exp;
    e_f[0] = 1; e_cx[0] = 10; e_cy[0] = 5; e_w[0] = 3; e_h[0] = 2;
    send_frame(NP, 0);
    wait_report("midrst");
    chk("midrst_one_valid", vcount, v0 + 1);
    check_all("midrst");

    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < N; k++)
        for (int j = 0; j < 3; j++) begin
          int lo, hi;
          lo = $urandom_range(0, 200);
          hi = lo + $urandom_range(0, 120);
          if (hi > 255) hi = 255;
          if ($urandom_range(0, 7) == 0) begin
            int t;
            t = lo; lo = hi + 1; hi = t;
            if (lo > 255) begin lo = 255; hi = 254; end
          end
          cfg_lo[24*k+8*j +: 8] = 8'(lo);
          cfg_hi[24*k+8*j +: 8] = 8'(hi);
        end
      cfg_min_pixels = NW'($urandom_range(0, 15));
      for (int p = 0; p < NP; p++)
        px[p] = {pal[$urandom_range(0, 4)], pal[$urandom_range(0, 4)], 8'($urandom_range(0, 255))};
      model_frame();
      send_frame(NP, 0);
      wait_report($sformatf("rnd%0d", r));
      check_all($sformatf("rnd%0d", r));
      send_frame(NP, 1);
      wait_report($sformatf("rndgap%0d", r));
      check_all($sformatf("rndgap%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multi_color_tracker.md
Name: multi_color_tracker

Overview:
Streaming colour-blob tracker: receives one 24-bit BMP-order pixel per accepted beat in raster order and classifies it against NUM_TRACKERS independent colour windows. Per frame, it reports one bounding box per tracker (center, width, height, found flag). It sits downstream of the pixel input FIFO and generalises the single-colour green-dot tracker to N colours, runtime thresholds, a minimum-area filter and a ready/valid input.

Parameters:
WIDTH, 720, pixels per line
HEIGHT, 540, lines per frame
NUM_TRACKERS, 4, independent colour windows
COORD_W, 12, coordinate/size width; must satisfy 2**COORD_W > max(WIDTH,HEIGHT)
CNT_W, 20, per-tracker matched-pixel counter width

Ports:
clock  in  1  single clock
reset  in  1  synchronous, active-low reset (asserted when 0)
in_valid  in  1  pixel beat valid
in_ready  out  1  block can accept a beat
in_din  in  24  pixel; [23:16]=B, [15:8]=G, [7:0]=R
cfg_lo  in  24*NUM_TRACKERS  per-tracker inclusive lower bound {B,G,R}; tracker k at [24k+:24]
cfg_hi  in  24*NUM_TRACKERS  per-tracker inclusive upper bound {B,G,R}
cfg_min_pixels  in  CNT_W  minimum matched count for found=1 (shared)
out_valid  out  1  one-cycle pulse, results valid
out_found  out  NUM_TRACKERS  bit k = tracker k found
out_center_x  out  COORD_W*NUM_TRACKERS  per-tracker center x
out_center_y  out  COORD_W*NUM_TRACKERS  per-tracker center y
out_width  out  COORD_W*NUM_TRACKERS  per-tracker bbox width
out_height  out  COORD_W*NUM_TRACKERS  per-tracker bbox height
frame_count  out  16  completed frames, wraps at 0xFFFF

Behaviour:
- Reset (reset==0 at a clock edge): all outputs 0; in_ready 0 during reset; x=y=0; state ACCUM; accumulators cleared. in_ready goes 1 on the first cycle after release.
- Beat accepted when in_valid && in_ready. x increments per beat and wraps to 0 at WIDTH-1 with y++. The beat at (WIDTH-1, HEIGHT-1) ends the frame.
- Match k: all three components satisfy cfg_lo_k <= c <= cfg_hi_k (unsigned). cfg is sampled on the accepting cycle; changing cfg mid-frame is legal and takes effect per beat.
- On a match: min_x/max_x/min_y/max_y update; count_k saturates at 2**CNT_W-1. First match sets min=max=current coordinate (per-tracker "seen" bit).
- States:
  - ACCUM: in_ready=1. Last beat -> REPORT0.
  - REPORT0: in_ready=0; compute width=max-min+1, height likewise, center=(min+max)>>1 (COORD_W+1-bit sum, floor). found = seen && count>=cfg_min_pixels. Go to REPORT1.
  - REPORT1: in_ready=0; register all outputs, out_valid=1 for this cycle only, frame_count++; clear accumulators and seen bits, x=y=0. Go to ACCUM.
- Latency: out_valid asserts 2 cycles after the edge accepting the last beat. Input stalls exactly 2 cycles per frame.
- Tracker with found=0: center/width/height outputs are 0 (no stale data).
- Result outputs hold their values until the next REPORT1; only out_valid pulses.
- in_valid low in ACCUM: no state change. in_valid during REPORT*: not accepted (in_ready=0); source must hold.
- Reset mid-frame: partial frame discarded, no out_valid; frame_count returns to 0.
- cfg_min_pixels=0: found = seen (at least one match still required).
- cfg_lo > cfg_hi for a component: tracker never matches.

Optional Feature:
TRACKER_SOF_EN: when defined, adds port in_sof (in, 1), qualified by acceptance. An accepted beat with in_sof=1 is treated as pixel (0,0): it discards the current accumulation without reporting, then accumulates this beat. An accepted beat at (0,0) with in_sof=0 is still accepted; a sticky status output sof_err (out, 1, cleared only by reset) sets. Without the macro: no in_sof/sof_err ports; framing is purely count-based.

Test Plan:
- WIDTH=720, HEIGHT=540; black frame with a 4x4 pure-green block at x=360..363, y=100..103; tracker0 lo={0,200,0}, hi={50,255,50}, min_pixels=16 -> out_found[0]=1, center=(361,101), width=4, height=4, frame_count=1; other trackers found=0 with zero outputs.
- Same frame, min_pixels=17 -> found[0]=0 and outputs 0. Single red pixel at (0,0) on tracker1 with min_pixels=1 -> center (0,0), width=1, height=1.
- WIDTH=16, HEIGHT=8; in_valid randomly deasserted 50% of cycles -> results identical to the back-to-back run. in_ready=0 for exactly 2 cycles; out_valid exactly 2 cycles after the last beat.
- Two consecutive frames, object moves from (2,2) to (12,6) -> second report reflects only frame 2 (accumulators cleared); frame_count=2.
- Reset asserted at beat 60 of a 128-beat frame, then a full frame sent -> no out_valid before the full frame; frame_count=1 after it.
- With TRACKER_SOF_EN: in_sof at beat 50 of a frame -> no report for the aborted frame; next report covers only pixels from the SOF beat onward; sof_err stays 0.
